// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: MIPS-style control decoder with ID/EX, EX/MEM and MEM/WB control registers.
//
// Decodes the ID-stage opcode combinationally and carries the resulting controls down the
// pipeline. Controls appear on ex_* one cycle, mem_* two cycles and wb_* three cycles after
// the opcode is sampled.
//
// Optional feature: define DECODE_CTRL_PIPE_LOAD_USE_EN to enable load-use hazard detection
// on stall_out. Without it stall_out is tied low and no hazard comparators are built.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   op, select                ID-stage opcode and rt field (REGIMM sub-decode)
//   id_rs, id_rt, id_rd       ID-stage register fields
//   stall_in                  downstream hold of the whole pipeline
//   flush_id                  kill the instruction currently in ID
//   stall_out                 load-use hazard request (hold PC and IF/ID)
//   ex_*                      EX-stage controls
//   mem_wr, mem_to_reg        MEM-stage controls
//   wb_reg_wr, wb_wr_addr     WB-stage write enable and destination
module decode_ctrl_pipe #(
  parameter int unsigned ALUOP_W  = 5,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LINK_REG = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [4:0]         select,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               stall_in,
  input  logic               flush_id,
  output logic               stall_out,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_ext_op,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_rtype,
  output logic               ex_illegal,
  output logic               mem_wr,
  output logic               mem_to_reg,
  output logic               wb_reg_wr,
  output logic [REG_AW-1:0]  wb_wr_addr
);

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               ext_op;
    logic               branch;
    logic               jump;
    logic               rtype;
    logic               illegal;
    logic               mem_wr;
    logic               mem_to_reg;
    logic               reg_wr;
    logic [REG_AW-1:0]  wr_addr;
  } ctrl_t;

  typedef struct packed {
    logic              mem_wr;
    logic              mem_to_reg;
    logic              reg_wr;
    logic [REG_AW-1:0] wr_addr;
  } mem_ctrl_t;

  typedef struct packed {
    logic              reg_wr;
    logic [REG_AW-1:0] wr_addr;
  } wb_ctrl_t;

  ctrl_t     bubble, dec;
  ctrl_t     idex_d, idex_q;
  mem_ctrl_t exmem_d, exmem_q;
  wb_ctrl_t  memwb_d, memwb_q;

  always_comb begin
    bubble        = '0;
    bubble.alu_op = '1;
  end

  // ID-stage decode
  always_comb begin
    dec = bubble;
    unique case (op)
      6'b000000: begin // R-type
        dec.rtype   = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.wr_addr = id_rd;
      end
      6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec.alu_src = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.wr_addr = id_rt;
        dec.ext_op  = (op == 6'b001001) || (op == 6'b001010) || (op == 6'b001011);
        unique case (op[2:0])
          3'b001:  dec.alu_op = ALUOP_W'(5'b00000); // ADDIU
          3'b010:  dec.alu_op = ALUOP_W'(5'b00010); // SLTI
          3'b011:  dec.alu_op = ALUOP_W'(5'b01000); // SLTIU
          3'b100:  dec.alu_op = ALUOP_W'(5'b00011); // ANDI
          3'b101:  dec.alu_op = ALUOP_W'(5'b00101); // ORI
          3'b110:  dec.alu_op = ALUOP_W'(5'b00110); // XORI
          default: dec.alu_op = ALUOP_W'(5'b10100); // LUI
        endcase
      end
      6'b100011, 6'b100000, 6'b100100: begin // LW, LB, LBU
        dec.alu_op     = '0;
        dec.alu_src    = 1'b1;
        dec.ext_op     = (op != 6'b100100);
        dec.reg_wr     = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.wr_addr    = id_rt;
      end
      6'b101011, 6'b101000: begin // SW, SB
        dec.alu_op  = '0;
        dec.alu_src = 1'b1;
        dec.ext_op  = 1'b1;
        dec.mem_wr  = 1'b1;
      end
      6'b000100: begin dec.branch = 1'b1; dec.alu_op = ALUOP_W'(5'b00001); end // BEQ
      6'b000101: begin dec.branch = 1'b1; dec.alu_op = ALUOP_W'(5'b10110); end // BNE
      6'b000110: begin dec.branch = 1'b1; dec.alu_op = ALUOP_W'(5'b10010); end // BLEZ
      6'b000111: begin dec.branch = 1'b1; dec.alu_op = ALUOP_W'(5'b10001); end // BGTZ
      6'b000001: begin // REGIMM: BGEZ when select==1, else BLTZ
        dec.branch = 1'b1;
        dec.alu_op = (select == 5'd1) ? ALUOP_W'(5'b10000) : ALUOP_W'(5'b10011);
      end
      6'b000010: dec.jump = 1'b1; // J
      6'b000011: begin // JAL
        dec.jump    = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.wr_addr = REG_AW'(LINK_REG);
      end
      default: dec.illegal = 1'b1;
    endcase
    // Register 0 is never written.
    if (dec.wr_addr == '0) dec.reg_wr = 1'b0;
  end

`ifdef DECODE_CTRL_PIPE_LOAD_USE_EN
  assign stall_out = idex_q.mem_to_reg && (idex_q.wr_addr != '0) &&
                     ((idex_q.wr_addr == id_rs) || (idex_q.wr_addr == id_rt)) && !stall_in;
`else
  logic unused_hazard_srcs;
  assign unused_hazard_srcs = ^{id_rs, id_rt};
  assign stall_out = 1'b0;
`endif

  // stall_in wins over flush_id; the flush requester re-asserts on a later cycle.
  always_comb begin
    if (stall_in)                   idex_d = idex_q;
    else if (flush_id || stall_out) idex_d = bubble;
    else                            idex_d = dec;
  end

  always_comb begin
    exmem_d = stall_in ? exmem_q
                       : '{mem_wr: idex_q.mem_wr, mem_to_reg: idex_q.mem_to_reg,
                           reg_wr: idex_q.reg_wr, wr_addr: idex_q.wr_addr};
    memwb_d = stall_in ? memwb_q : '{reg_wr: exmem_q.reg_wr, wr_addr: exmem_q.wr_addr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= bubble;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_alu_op  = idex_q.alu_op;
  assign ex_alu_src = idex_q.alu_src;
  assign ex_ext_op  = idex_q.ext_op;
  assign ex_branch  = idex_q.branch;
  assign ex_jump    = idex_q.jump;
  assign ex_rtype   = idex_q.rtype;
  assign ex_illegal = idex_q.illegal;
  assign mem_wr     = exmem_q.mem_wr;
  assign mem_to_reg = exmem_q.mem_to_reg;
  assign wb_reg_wr  = memwb_q.reg_wr;
  assign wb_wr_addr = memwb_q.wr_addr;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Testbench for decode_ctrl_pipe: directed scenarios plus randomized traffic checked against
// an instruction-level reference model (each pipeline slot holds the decoded record of one
// instruction, shifted along as the pipeline advances).
module tb_decode_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [4:0] sel;
  logic [4:0] rs, rt, rd;
  logic       stall_in, flush_id;
  logic       stall_out;
  logic [4:0] ex_alu_op;
  logic       ex_alu_src, ex_ext_op, ex_branch, ex_jump, ex_rtype, ex_illegal;
  logic       mem_wr, mem_to_reg, wb_reg_wr;
  logic [4:0] wb_wr_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .select     (sel),
    .id_rs      (rs),
    .id_rt      (rt),
    .id_rd      (rd),
    .stall_in   (stall_in),
    .flush_id   (flush_id),
    .stall_out  (stall_out),
    .ex_alu_op  (ex_alu_op),
    .ex_alu_src (ex_alu_src),
    .ex_ext_op  (ex_ext_op),
    .ex_branch  (ex_branch),
    .ex_jump    (ex_jump),
    .ex_rtype   (ex_rtype),
    .ex_illegal (ex_illegal),
    .mem_wr     (mem_wr),
    .mem_to_reg (mem_to_reg),
    .wb_reg_wr  (wb_reg_wr),
    .wb_wr_addr (wb_wr_addr)
  );

  typedef struct packed {
    logic [4:0] alu_op;
    logic alu_src, ext_op, branch, jump, rtype, illegal, mem_wr, mem_to_reg, reg_wr;
    logic [4:0] wr_addr;
  } rec_t;

  rec_t pipe [3]; // 0: EX, 1: MEM, 2: WB

  function automatic rec_t bub();
    rec_t r = '0;
    r.alu_op = 5'h1f;
    return r;
  endfunction

  // Instruction-level decode table.
  function automatic rec_t ref_decode(logic [5:0] o, logic [4:0] s, logic [4:0] a_rt,
                                      logic [4:0] a_rd);
    rec_t r = bub();
    case (o)
      6'h00: begin r.rtype = 1; r.reg_wr = 1; r.wr_addr = a_rd; end
      6'h09: begin r.alu_op = 5'h00; r.alu_src = 1; r.ext_op = 1; r.reg_wr = 1; r.wr_addr = a_rt; end
      6'h0a: begin r.alu_op = 5'h02; r.alu_src = 1; r.ext_op = 1; r.reg_wr = 1; r.wr_addr = a_rt; end
      6'h0b: begin r.alu_op = 5'h08; r.alu_src = 1; r.ext_op = 1; r.reg_wr = 1; r.wr_addr = a_rt; end
      6'h0c: begin r.alu_op = 5'h03; r.alu_src = 1; r.reg_wr = 1; r.wr_addr = a_rt; end
      6'h0d: begin r.alu_op = 5'h05; r.alu_src = 1; r.reg_wr = 1; r.wr_addr = a_rt; end
      6'h0e: begin r.alu_op = 5'h06; r.alu_src = 1; r.reg_wr = 1; r.wr_addr = a_rt; end
      6'h0f: begin r.alu_op = 5'h14; r.alu_src = 1; r.reg_wr = 1; r.wr_addr = a_rt; end
      6'h23, 6'h20: begin
        r.alu_op = 0; r.alu_src = 1; r.ext_op = 1; r.reg_wr = 1; r.mem_to_reg = 1; r.wr_addr = a_rt;
      end
      6'h24: begin r.alu_op = 0; r.alu_src = 1; r.reg_wr = 1; r.mem_to_reg = 1; r.wr_addr = a_rt; end
      6'h2b, 6'h28: begin r.alu_op = 0; r.alu_src = 1; r.ext_op = 1; r.mem_wr = 1; end
      6'h04: begin r.branch = 1; r.alu_op = 5'h01; end
      6'h05: begin r.branch = 1; r.alu_op = 5'h16; end
      6'h06: begin r.branch = 1; r.alu_op = 5'h12; end
      6'h07: begin r.branch = 1; r.alu_op = 5'h11; end
      6'h01: begin r.branch = 1; r.alu_op = (s == 1) ? 5'h10 : 5'h13; end
      6'h02: r.jump = 1;
      6'h03: begin r.jump = 1; r.reg_wr = 1; r.wr_addr = 5'd31; end
      default: r.illegal = 1;
    endcase
    if (r.wr_addr == 0) r.reg_wr = 0;
    return r;
  endfunction

  function automatic logic model_stall();
`ifdef DECODE_CTRL_PIPE_LOAD_USE_EN
    return pipe[0].mem_to_reg && pipe[0].wr_addr != 0 &&
           (pipe[0].wr_addr == rs || pipe[0].wr_addr == rt) && !stall_in;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [19:0] obs_vec();
    return {ex_alu_op, ex_alu_src, ex_ext_op, ex_branch, ex_jump, ex_rtype, ex_illegal,
            mem_wr, mem_to_reg, wb_reg_wr, wb_wr_addr, stall_out};
  endfunction

  function automatic logic [19:0] exp_vec();
    return {pipe[0].alu_op, pipe[0].alu_src, pipe[0].ext_op, pipe[0].branch, pipe[0].jump,
            pipe[0].rtype, pipe[0].illegal, pipe[1].mem_wr, pipe[1].mem_to_reg,
            pipe[2].reg_wr, pipe[2].wr_addr, model_stall()};
  endfunction

  task automatic drive(logic [5:0] o, logic [4:0] s, logic [4:0] a_rs, logic [4:0] a_rt,
                       logic [4:0] a_rd, logic st, logic fl, logic r);
    op = o; sel = s; rs = a_rs; rt = a_rt; rd = a_rd;
    stall_in = st; flush_id = fl; rst = r;
    #1;
  endtask

  // Advance one clock and move the model along with it.
  task automatic tick();
    rec_t nx [3];
    rec_t d;
    logic hz;
    d  = ref_decode(op, sel, rt, rd);
    hz = model_stall();
    nx = pipe;
    if (rst) begin
      nx[0] = bub(); nx[1] = bub(); nx[2] = bub();
    end else if (!stall_in) begin
      nx[2] = pipe[1];
      nx[1] = pipe[0];
      nx[0] = (flush_id || hz) ? bub() : d;
    end
    @(posedge clk);
    #1;
    pipe = nx;
  endtask

  task automatic nop();
    drive(6'h00, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    logic [19:0] v;
    drive(6'h23, 0, 1, 7, 0, 1, 1, 1); // rst overrides stall and flush
    tick();
    drive(6'h00, 0, 0, 0, 0, 0, 0, 1);
    tick();
    v = obs_vec();
    checks++;
    if (v !== {5'h1f, 6'b0, 2'b0, 1'b0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL reset_state: got %h want %h", v, {5'h1f, 15'd0});
    end
    checks++;
    if (ex_alu_op !== 5'h1f) begin
      errors++; $display("FAIL reset_alu_op: got %b want 11111", ex_alu_op);
    end
  endtask

  task automatic test_addiu();
    drive(6'h09, 0, 1, 3, 0, 0, 0, 0);
    tick();
    checks++;
    if ({ex_alu_src, ex_ext_op, ex_alu_op} !== {1'b1, 1'b1, 5'h00}) begin
      errors++; $display("FAIL addiu_ex: got src=%b ext=%b op=%b want 1 1 00000",
                         ex_alu_src, ex_ext_op, ex_alu_op);
    end
    nop();
    nop();
    checks++;
    if ({wb_reg_wr, wb_wr_addr} !== {1'b1, 5'd3}) begin
      errors++; $display("FAIL addiu_wb: got wr=%b addr=%0d want 1 3", wb_reg_wr, wb_wr_addr);
    end
  endtask

  task automatic test_load_use();
    drive(6'h23, 0, 2, 5, 0, 0, 0, 0); // LW r5
    tick();
    drive(6'h00, 0, 5, 6, 7, 0, 0, 0); // ADDU r7 = r5 + r6
`ifdef DECODE_CTRL_PIPE_LOAD_USE_EN
    checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall_out); end
    tick();
    checks++;
    if ({ex_rtype, ex_alu_op, stall_out} !== {1'b0, 5'h1f, 1'b0}) begin
      errors++; $display("FAIL lu_bubble: got rtype=%b op=%b stall=%b want 0 11111 0",
                         ex_rtype, ex_alu_op, stall_out);
    end
    checks++;
    if (mem_to_reg !== 1'b1) begin errors++; $display("FAIL lu_mem: got %b want 1", mem_to_reg); end
    tick();
`else
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL lu_stall: got %b want 0", stall_out); end
    tick();
    checks++;
    if (mem_to_reg !== 1'b1) begin errors++; $display("FAIL lu_mem: got %b want 1", mem_to_reg); end
`endif
    checks++;
    if (ex_rtype !== 1'b1) begin errors++; $display("FAIL lu_addu: got rtype=%b want 1", ex_rtype); end
  endtask

  task automatic test_regimm();
    drive(6'h01, 1, 0, 1, 0, 0, 0, 0);
    tick();
    checks++;
    if ({ex_alu_op, ex_branch} !== {5'b10000, 1'b1}) begin
      errors++; $display("FAIL bgez: got op=%b br=%b want 10000 1", ex_alu_op, ex_branch);
    end
    drive(6'h01, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if ({ex_alu_op, ex_branch} !== {5'b10011, 1'b1}) begin
      errors++; $display("FAIL bltz: got op=%b br=%b want 10011 1", ex_alu_op, ex_branch);
    end
  endtask

  task automatic test_flush();
    logic seen;
    logic [19:0] v;
    drive(6'h2b, 0, 1, 2, 0, 0, 1, 0); // flushed SW
    tick();
    seen = mem_wr;
    for (int i = 0; i < 3; i++) begin
      nop();
      seen = seen | mem_wr;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_sw: mem_wr got %b want 0", seen); end
    drive(6'h23, 0, 1, 4, 0, 0, 0, 0); // LW r4
    tick();
    drive(6'h09, 0, 1, 9, 0, 0, 0, 0); // ADDIU r9
    tick();
    drive(6'h2b, 0, 1, 2, 0, 1, 1, 0); // SW with flush and stall together
    tick();
    tick();
    v = obs_vec();
    checks++;
    if (v !== exp_vec()) begin
      errors++; $display("FAIL flush_stall_hold: got %h want %h", v, exp_vec());
    end
    checks++;
    if ({ex_alu_src, ex_ext_op, mem_to_reg, mem_wr} !== 4'b1110) begin
      errors++; $display("FAIL flush_stall_fields: got %b want 1110",
                         {ex_alu_src, ex_ext_op, mem_to_reg, mem_wr});
    end
  endtask

  task automatic test_illegal_jal();
    logic [19:0] v;
    logic [10:0] exs;
    drive(6'h3f, 0, 0, 0, 0, 0, 0, 0);
    tick();
    v   = obs_vec();
    exs = v[19:9];
    checks++;
    if (exs !== {5'h1f, 6'b000001}) begin
      errors++; $display("FAIL illegal: got %b want 11111000001", exs);
    end
    drive(6'h03, 0, 0, 0, 0, 0, 0, 0);
    tick();
    nop();
    nop();
    checks++;
    if ({wb_reg_wr, wb_wr_addr} !== {1'b1, 5'd31}) begin
      errors++; $display("FAIL jal_wb: got wr=%b addr=%0d want 1 31", wb_reg_wr, wb_wr_addr);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [21];
    logic [19:0] v;
    ops = '{6'h00, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h20, 6'h24,
            6'h2b, 6'h28, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03, 6'h23};
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 20)],
            5'($urandom_range(0, 2)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 40) == 0);
      checks++;
      if (stall_out !== model_stall()) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall_out, model_stall());
      end
      tick();
      v = obs_vec();
      checks++;
      if (v !== exp_vec()) begin
        errors++; $display("FAIL rnd_outputs[%0d]: got %h want %h", i, v, exp_vec());
      end
    end
  endtask

  initial begin
    pipe[0] = bub(); pipe[1] = bub(); pipe[2] = bub();
    drive(6'h00, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    test_reset();
    test_addiu();
    test_load_use();
    test_regimm();
    test_flush();
    test_illegal_jal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
